decode_stage_buffer: RTL

- Decode-stage holding buffer between fetch and execute.
- Accepts {instruction, pc} from fetch over a valid/ready handshake and stores up to 2 entries (skid FIFO).
- Decodes each entry's immediate and legality on entry, then presents entries in order to execute over a second valid/ready handshake.
- Sequences the Immediate_Generator: exactly one instance, fed from the input port. Adds flush, back-pressure and a decoded-instruction counter.

---
 rtl/decode_stage_buffer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/decode_stage_buffer.sv
// Two-entry skid FIFO between fetch and execute. The immediate and legality of each
// instruction are decoded as it is pushed and stored with the entry.
module decode_stage_buffer #(
  parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0013,
  parameter bit          ILLEGAL_CHECK   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instruction,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic [31:0] out_immediate,
  output logic        out_illegal,
  output logic [31:0] decoded_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} count_e;

  count_e      count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] decoded_count_q, decoded_count_d;

  logic [31:0] instr_mem_q [2];
  logic [31:0] pc_mem_q    [2];
  logic [31:0] imm_mem_q   [2];
  logic        ill_mem_q   [2];

  logic        push, pop;
  logic [31:0] imm_dec;
  logic        ill_dec;

  assign in_ready  = !reset && (count_q != StFull);
  assign out_valid = (count_q != StEmpty);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Immediate generator; branch offsets are reported relative to pc+4.
  always_comb begin
    imm_dec = 32'h0;
    ill_dec = 1'b0;
    unique case (in_instruction[6:0])
      7'b0110011: imm_dec = 32'h0;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111:
        imm_dec = {{20{in_instruction[31]}}, in_instruction[31:20]};
      7'b0100011:
        imm_dec = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
      7'b1100011:
        imm_dec = {{19{in_instruction[31]}}, in_instruction[31], in_instruction[7],
                   in_instruction[30:25], in_instruction[11:8], 1'b0} - 32'd4;
      7'b1101111:
        imm_dec = {{11{in_instruction[31]}}, in_instruction[31], in_instruction[19:12],
                   in_instruction[20], in_instruction[30:21], 1'b0};
      7'b0110111, 7'b0010111: imm_dec = {in_instruction[31:12], 12'h000};
      default: ill_dec = 1'b1;
    endcase
    if (in_instruction[1:0] != 2'b11) ill_dec = 1'b1;
    if (!ILLEGAL_CHECK) ill_dec = 1'b0;
  end

  always_comb begin
    count_d         = count_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    decoded_count_d = decoded_count_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop) begin
      rd_ptr_d        = ~rd_ptr_q;
      decoded_count_d = decoded_count_q + 32'd1;
    end
    if (push && !pop) begin
      count_d = (count_q == StEmpty) ? StOne : StFull;
    end else if (pop && !push) begin
      count_d = (count_q == StFull) ? StOne : StEmpty;
    end
    if (flush) begin
      count_d         = StEmpty;
      wr_ptr_d        = 1'b0;
      rd_ptr_d        = 1'b0;
      decoded_count_d = decoded_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q         <= StEmpty;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      decoded_count_q <= 32'h0;
    end else begin
      count_q         <= count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      decoded_count_q <= decoded_count_d;
    end
  end

  // Payload storage is deliberately left unreset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem_q[wr_ptr_q] <= in_instruction;
      pc_mem_q[wr_ptr_q]    <= in_pc;
      imm_mem_q[wr_ptr_q]   <= imm_dec;
      ill_mem_q[wr_ptr_q]   <= ill_dec;
    end
  end

  always_comb begin
    out_instruction = NOP_INSTRUCTION;
    out_pc          = 32'h0;
    out_immediate   = 32'h0;
    out_illegal     = 1'b0;
    if (out_valid) begin
      out_instruction = instr_mem_q[rd_ptr_q];
      out_pc          = pc_mem_q[rd_ptr_q];
      out_immediate   = imm_mem_q[rd_ptr_q];
      out_illegal     = ill_mem_q[rd_ptr_q];
    end
  end

  assign decoded_count = decoded_count_q;

endmodule
